// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
// Optional feature macro used by the engine: I2C_SLV_GC_EN (general-call match).
package i2c_pkg;

  typedef enum logic [3:0] {
    I2C_SLV_IDLE,
    I2C_SLV_ADDR,
    I2C_SLV_ADDR_ACK,
    I2C_SLV_RX_BYTE,
    I2C_SLV_RX_ACK,
    I2C_SLV_TX_LOAD,
    I2C_SLV_TX_BYTE,
    I2C_SLV_TX_ACK,
    I2C_SLV_WAIT_STOP
  } i2c_slv_state_e;

  localparam logic [6:0] GC_ADDR = 7'h00;
  localparam logic       RW_READ = 1'b1;

  // True when the upper seven bits of an address byte equal the given address.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_bus_mon.sv
// Bus monitor: registers SCL/SDA, produces START/STOP and SCL edge pulses
// (each pulse appears one cycle after the bus change) and the bus-busy flag.
module i2c_bus_mon (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_q,
  output logic sda_q,
  output logic start_p,
  output logic stop_p,
  output logic scl_rise,
  output logic scl_fall,
  output logic bb
);

  // Sample the bus and flag edges/conditions against the previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
      start_p  <= 1'b0;
      stop_p   <= 1'b0;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      bb       <= 1'b0;
    end else begin
      scl_q    <= scl_i;
      sda_q    <= sda_i;
      // SCL must be high in both samples so an SDA change at an SCL edge is not a condition.
      start_p  <= scl_q & scl_i & sda_q & ~sda_i;
      stop_p   <= scl_q & scl_i & ~sda_q & sda_i;
      scl_rise <= ~scl_q & scl_i;
      scl_fall <= scl_q & ~scl_i;
      if (scl_q & scl_i & ~sda_q & sda_i)
        bb <= 1'b0;
      else if (scl_q & scl_i & sda_q & ~sda_i)
        bb <= 1'b1;
    end
  end

endmodule

// File: rtl/i2c_slv_ctrl.sv
// Byte-level I2C target engine: address match, ACK, RX FIFO push, TX FIFO pop,
// SCL stretching while a FIFO is not ready.
// Define I2C_SLV_GC_EN to also accept the general-call address (0x00, write).
module i2c_slv_ctrl
  import i2c_pkg::*;
#(
  parameter int HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cr_en,
  input  logic [6:0] slv_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       rx_fifo_full,
  output logic       rx_fifo_wr,
  output logic [7:0] rx_fifo_din,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_rd,
  input  logic [7:0] tx_fifo_dout,
  output logic       bb,
  output logic       aas,
  output logic       srw,
  output logic       gc_hit,
  output logic       stop_det,
  output logic       nak_det
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

  logic scl_q, sda_q, start_p, stop_p, scl_rise, scl_fall;

  i2c_bus_mon u_bus_mon (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_q    (scl_q),
    .sda_q    (sda_q),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .bb       (bb)
  );

  i2c_slv_state_e state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  // A scheduled SDA level, applied once the hold counter has run out.
  logic          pend_reg, pend_next;
  logic          sda_pend_reg, sda_pend_next;
  // Per-state sub-phase: byte complete / ACK driven / master ACKed.
  logic          phase_reg, phase_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          scl_oe_reg, scl_oe_next;
  logic          aas_reg, aas_next;
  logic          srw_reg, srw_next;
  logic          gc_hit_reg, gc_hit_next;
  logic          stop_det_reg, stop_det_next;
  logic          nak_det_reg, nak_det_next;
  logic          rx_wr_reg, rx_wr_next;
  logic [7:0]    rx_din_reg, rx_din_next;
  logic          tx_rd_reg, tx_rd_next;
  logic [7:0]    byte_in;

  assign byte_in = {shift_reg[6:0], sda_q};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= I2C_SLV_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      hold_cnt_reg <= '0;
      pend_reg     <= 1'b0;
      sda_pend_reg <= 1'b0;
      phase_reg    <= 1'b0;
      sda_oe_reg   <= 1'b0;
      scl_oe_reg   <= 1'b0;
      aas_reg      <= 1'b0;
      srw_reg      <= 1'b0;
      gc_hit_reg   <= 1'b0;
      stop_det_reg <= 1'b0;
      nak_det_reg  <= 1'b0;
      rx_wr_reg    <= 1'b0;
      rx_din_reg   <= '0;
      tx_rd_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      hold_cnt_reg <= hold_cnt_next;
      pend_reg     <= pend_next;
      sda_pend_reg <= sda_pend_next;
      phase_reg    <= phase_next;
      sda_oe_reg   <= sda_oe_next;
      scl_oe_reg   <= scl_oe_next;
      aas_reg      <= aas_next;
      srw_reg      <= srw_next;
      gc_hit_reg   <= gc_hit_next;
      stop_det_reg <= stop_det_next;
      nak_det_reg  <= nak_det_next;
      rx_wr_reg    <= rx_wr_next;
      rx_din_reg   <= rx_din_next;
      tx_rd_reg    <= tx_rd_next;
    end
  end

  // Next-state, bus drive and FIFO strobe logic.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    hold_cnt_next = (hold_cnt_reg != '0) ? hold_cnt_reg - 1'b1 : hold_cnt_reg;
    pend_next     = pend_reg;
    sda_pend_next = sda_pend_reg;
    phase_next    = phase_reg;
    sda_oe_next   = sda_oe_reg;
    scl_oe_next   = scl_oe_reg;
    aas_next      = aas_reg;
    srw_next      = srw_reg;
    gc_hit_next   = gc_hit_reg;
    stop_det_next = 1'b0;
    nak_det_next  = 1'b0;
    rx_wr_next    = 1'b0;
    rx_din_next   = rx_din_reg;
    tx_rd_next    = 1'b0;

    // Apply a scheduled SDA change once the data hold time has elapsed.
    if (pend_reg && hold_cnt_reg == '0) begin
      sda_oe_next = sda_pend_reg;
      pend_next   = 1'b0;
    end

    if (!cr_en) begin
      state_next  = I2C_SLV_IDLE;
      sda_oe_next = 1'b0;
      scl_oe_next = 1'b0;
      aas_next    = 1'b0;
      gc_hit_next = 1'b0;
      pend_next   = 1'b0;
      phase_next  = 1'b0;
    end else if (stop_p) begin
      state_next    = I2C_SLV_IDLE;
      sda_oe_next   = 1'b0;
      scl_oe_next   = 1'b0;
      aas_next      = 1'b0;
      gc_hit_next   = 1'b0;
      pend_next     = 1'b0;
      phase_next    = 1'b0;
      stop_det_next = 1'b1;
    end else if (start_p) begin
      state_next   = I2C_SLV_ADDR;
      sda_oe_next  = 1'b0;
      scl_oe_next  = 1'b0;
      aas_next     = 1'b0;
      gc_hit_next  = 1'b0;
      pend_next    = 1'b0;
      phase_next   = 1'b0;
      bit_cnt_next = '0;
      shift_next   = '0;
    end else begin
      case (state_reg)
        I2C_SLV_ADDR: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (addr_match(byte_in, slv_addr)) begin
                state_next = I2C_SLV_ADDR_ACK;
                aas_next   = 1'b1;
                srw_next   = byte_in[0];
              end
`ifdef I2C_SLV_GC_EN
              else if (byte_in == {GC_ADDR, ~RW_READ}) begin
                state_next  = I2C_SLV_ADDR_ACK;
                aas_next    = 1'b1;
                gc_hit_next = 1'b1;
                srw_next    = ~RW_READ;
              end
`endif
              else begin
                state_next = I2C_SLV_WAIT_STOP;
              end
            end
          end
        end

        I2C_SLV_ADDR_ACK: begin
          if (scl_fall) begin
            hold_cnt_next = HOLD_LOAD;
            pend_next     = 1'b1;
            if (!phase_reg) begin
              sda_pend_next = 1'b1;
              phase_next    = 1'b1;
            end else begin
              // ACK bit over: release SDA; a read replaces this with the MSB once loaded.
              sda_pend_next = 1'b0;
              phase_next    = 1'b0;
              state_next    = (srw_reg == RW_READ) ? I2C_SLV_TX_LOAD : I2C_SLV_RX_BYTE;
            end
          end
        end

        I2C_SLV_RX_BYTE: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7)
              phase_next = 1'b1;
          end else if (scl_fall && phase_reg) begin
            state_next    = I2C_SLV_RX_ACK;
            phase_next    = 1'b0;
            hold_cnt_next = HOLD_LOAD;
          end
        end

        I2C_SLV_RX_ACK: begin
          if (!phase_reg) begin
            // SCL is low here; keep it low while the FIFO is full, then push and ACK together.
            if (!rx_fifo_full && hold_cnt_reg == '0) begin
              rx_wr_next  = 1'b1;
              rx_din_next = shift_reg;
              sda_oe_next = 1'b1;
              scl_oe_next = 1'b0;
              phase_next  = 1'b1;
            end else if (rx_fifo_full) begin
              scl_oe_next = 1'b1;
            end
          end else if (scl_fall) begin
            state_next    = I2C_SLV_RX_BYTE;
            phase_next    = 1'b0;
            hold_cnt_next = HOLD_LOAD;
            pend_next     = 1'b1;
            sda_pend_next = 1'b0;
          end
        end

        I2C_SLV_TX_LOAD: begin
          if (tx_fifo_empty) begin
            scl_oe_next = 1'b1;
          end else begin
            tx_rd_next    = 1'b1;
            shift_next    = tx_fifo_dout;
            scl_oe_next   = 1'b0;
            bit_cnt_next  = '0;
            phase_next    = 1'b0;
            pend_next     = 1'b1;
            sda_pend_next = ~tx_fifo_dout[7];
            state_next    = I2C_SLV_TX_BYTE;
          end
        end

        I2C_SLV_TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7)
              phase_next = 1'b1;
          end else if (scl_fall) begin
            hold_cnt_next = HOLD_LOAD;
            pend_next     = 1'b1;
            if (phase_reg) begin
              sda_pend_next = 1'b0;
              phase_next    = 1'b0;
              state_next    = I2C_SLV_TX_ACK;
            end else begin
              shift_next    = {shift_reg[6:0], 1'b0};
              sda_pend_next = ~shift_reg[6];
            end
          end
        end

        I2C_SLV_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_q) begin
              phase_next = 1'b1;
            end else begin
              nak_det_next = 1'b1;
              sda_oe_next  = 1'b0;
              pend_next    = 1'b0;
              state_next   = I2C_SLV_WAIT_STOP;
            end
          end else if (scl_fall && phase_reg) begin
            phase_next    = 1'b0;
            hold_cnt_next = HOLD_LOAD;
            state_next    = I2C_SLV_TX_LOAD;
          end
        end

        I2C_SLV_IDLE, I2C_SLV_WAIT_STOP: begin
        end

        default: state_next = I2C_SLV_IDLE;
      endcase
    end
  end

  assign scl_oe      = scl_oe_reg;
  assign sda_oe      = sda_oe_reg;
  assign aas         = aas_reg;
  assign srw         = srw_reg;
  assign gc_hit      = gc_hit_reg;
  assign stop_det    = stop_det_reg;
  assign nak_det     = nak_det_reg;
  assign rx_fifo_wr  = rx_wr_reg;
  assign rx_fifo_din = rx_din_reg;
  assign tx_fifo_rd  = tx_rd_reg;

endmodule

// File: tb/tb_i2c_slv_ctrl.sv
// Testbench for i2c_slv_ctrl: bus-level I2C master model, FIFO models and
// a byte-level reference of what the target should ACK, store and return.
module tb_i2c_slv_ctrl;

  localparam int Q = 10;          // quarter SCL period in clk cycles
  localparam logic [6:0] OWN = 7'h3A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cr_en;
  logic [6:0] slv_addr;
  logic       scl_m, sda_m;
  logic       scl_line, sda_line;
  logic       scl_oe, sda_oe;
  logic       rx_fifo_full, rx_fifo_wr;
  logic [7:0] rx_fifo_din;
  logic       tx_fifo_empty, tx_fifo_rd;
  logic [7:0] tx_fifo_dout;
  logic       bb, aas, srw, gc_hit, stop_det, nak_det;

  // Open-drain bus: either side can pull low.
  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  // TX FIFO model (first-word-fall-through).
  logic [7:0] tx_mem [0:127];
  logic [6:0] tx_wp, tx_rp;
  assign tx_fifo_empty = (tx_wp == tx_rp);
  assign tx_fifo_dout  = tx_mem[tx_rp];

  // RX FIFO full window.
  int   cyc;
  int   full_until;
  logic full_force;
  assign rx_fifo_full = full_force && (cyc < full_until);

  // Observation counters.
  logic [7:0] rx_mem [0:127];
  logic [6:0] rx_cnt;
  int tx_rd_cnt, nak_cnt, stop_cnt, sda_oe_cyc, scl_oe_cyc, wr_full_err, rx_wr_cyc;

  int n_checks = 0;
  int n_errors = 0;

  i2c_slv_ctrl #(.HOLD_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cr_en         (cr_en),
    .slv_addr      (slv_addr),
    .scl_i         (scl_line),
    .sda_i         (sda_line),
    .scl_oe        (scl_oe),
    .sda_oe        (sda_oe),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_wr    (rx_fifo_wr),
    .rx_fifo_din   (rx_fifo_din),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rd    (tx_fifo_rd),
    .tx_fifo_dout  (tx_fifo_dout),
    .bb            (bb),
    .aas           (aas),
    .srw           (srw),
    .gc_hit        (gc_hit),
    .stop_det      (stop_det),
    .nak_det       (nak_det)
  );

  // Monitor: counts strobes and captures pushed bytes, away from the active edge.
  initial begin
    cyc = 0; tx_rp = '0; rx_cnt = '0; tx_rd_cnt = 0; nak_cnt = 0; stop_cnt = 0;
    sda_oe_cyc = 0; scl_oe_cyc = 0; wr_full_err = 0; rx_wr_cyc = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_fifo_rd) begin
      tx_rp     <= tx_rp + 7'd1;
      tx_rd_cnt <= tx_rd_cnt + 1;
    end
    if (rx_fifo_wr) begin
      rx_mem[rx_cnt] <= rx_fifo_din;
      rx_cnt         <= rx_cnt + 7'd1;
      rx_wr_cyc      <= cyc;
      if (rx_fifo_full) wr_full_err <= wr_full_err + 1;
    end
    if (nak_det)  nak_cnt    <= nak_cnt + 1;
    if (stop_det) stop_cnt   <= stop_cnt + 1;
    if (sda_oe)   sda_oe_cyc <= sda_oe_cyc + 1;
    if (scl_oe)   scl_oe_cyc <= scl_oe_cyc + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (scl_line !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      n_errors++;
      $error("FAIL scl_timeout: observed=scl_low expected=scl_high");
    end
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    tick(Q);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    wait_scl_high();
    tick(Q);
    s = sda_line;
    tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic master_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(~master_ack, s);
  endtask

  task automatic do_start();
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    wait_scl_high();
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic do_stop();
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    wait_scl_high();
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_mem[tx_wp] = d;
    tx_wp = tx_wp + 7'd1;
  endtask

  initial begin
    logic       ack, s, rw, hit, exp_ack;
    logic [7:0] d, abyte;
    logic [6:0] addr;
    logic [7:0] exp_q[$];
    int base, rd0, nak0, stop0, oe0, sc0, n;

    rst = 1'b1; cr_en = 1'b1; slv_addr = OWN; scl_m = 1'b1; sda_m = 1'b1;
    full_force = 1'b0; full_until = 0; tx_wp = '0;
    tick(5);
    chk("reset_outputs", 32'({scl_oe, sda_oe, bb, aas, srw, gc_hit, stop_det, nak_det, rx_fifo_wr, tx_fifo_rd}), 32'd0);
    chk("reset_rx_din", 32'(rx_fifo_din), 32'd0);
    rst = 1'b0;
    tick(5);
    chk("idle_release", 32'({scl_oe, sda_oe, aas}), 32'd0);

    // 1: write two bytes to own address.
    base = int'(rx_cnt); stop0 = stop_cnt;
    do_start();
    chk("t1_bb_set", 32'(bb), 32'd1);
    send_byte(8'h74, ack);
    chk("t1_addr_ack", 32'(ack), 32'd1);
    chk("t1_aas", 32'(aas), 32'd1);
    chk("t1_srw", 32'(srw), 32'd0);
    send_byte(8'hA5, ack);
    chk("t1_d0_ack", 32'(ack), 32'd1);
    send_byte(8'h5C, ack);
    chk("t1_d1_ack", 32'(ack), 32'd1);
    do_stop();
    tick(4);
    chk("t1_wr_count", 32'(int'(rx_cnt) - base), 32'd2);
    chk("t1_byte0", 32'(rx_mem[7'(base)]), 32'hA5);
    chk("t1_byte1", 32'(rx_mem[7'(base + 1)]), 32'h5C);
    chk("t1_stop_det", 32'(stop_cnt - stop0), 32'd1);
    chk("t1_aas_clr", 32'(aas), 32'd0);
    chk("t1_bb_clr", 32'(bb), 32'd0);

    // 2: address mismatch.
    base = int'(rx_cnt); oe0 = sda_oe_cyc;
    do_start();
    send_byte(8'h52, ack);
    chk("t2_addr_nak", 32'(ack), 32'd0);
    send_byte(8'h3C, ack);
    chk("t2_data_nak", 32'(ack), 32'd0);
    chk("t2_aas", 32'(aas), 32'd0);
    do_stop();
    tick(4);
    chk("t2_no_sda", 32'(sda_oe_cyc - oe0), 32'd0);
    chk("t2_no_wr", 32'(int'(rx_cnt) - base), 32'd0);

    // 3: read two bytes, NAK the second.
    tx_push(8'hC3); tx_push(8'h0F);
    rd0 = tx_rd_cnt; nak0 = nak_cnt;
    do_start();
    send_byte(8'h75, ack);
    chk("t3_addr_ack", 32'(ack), 32'd1);
    chk("t3_srw", 32'(srw), 32'd1);
    recv_byte(d, 1'b1);
    chk("t3_byte0", 32'(d), 32'hC3);
    recv_byte(d, 1'b0);
    chk("t3_byte1", 32'(d), 32'h0F);
    tick(2);
    chk("t3_nak_det", 32'(nak_cnt - nak0), 32'd1);
    do_stop();
    chk("t3_rd_count", 32'(tx_rd_cnt - rd0), 32'd2);

    // 4: read with empty TX FIFO stretches SCL until a byte arrives.
    rd0 = tx_rd_cnt;
    do_start();
    send_byte(8'h75, ack);
    chk("t4_addr_ack", 32'(ack), 32'd1);
    tick(30);
    chk("t4_stretch", 32'(scl_oe), 32'd1);
    tick(50);
    chk("t4_still_stretch", 32'({scl_oe, 1'b0} | 2'(tx_rd_cnt - rd0)), 32'd2);
    tx_push(8'h81);
    recv_byte(d, 1'b0);
    chk("t4_byte", 32'(d), 32'h81);
    chk("t4_scl_free", 32'(scl_oe), 32'd0);
    do_stop();
    chk("t4_rd_count", 32'(tx_rd_cnt - rd0), 32'd1);

    // 5: RX FIFO full during a write stretches SCL after bit 8.
    base = int'(rx_cnt);
    do_start();
    send_byte(8'h74, ack);
    chk("t5_addr_ack", 32'(ack), 32'd1);
    sc0 = scl_oe_cyc;
    full_force = 1'b1;
    full_until = cyc + 500;
    send_byte(8'h3C, ack);
    chk("t5_ack", 32'(ack), 32'd1);
    chk("t5_wr_count", 32'(int'(rx_cnt) - base), 32'd1);
    chk("t5_byte", 32'(rx_mem[7'(base)]), 32'h3C);
    chk("t5_wr_after_full", 32'(rx_wr_cyc >= full_until), 32'd1);
    chk("t5_stretched", 32'((scl_oe_cyc - sc0) > 100), 32'd1);
    chk("t5_no_wr_full", 32'(wr_full_err), 32'd0);
    full_force = 1'b0;
    do_stop();

    // 6: repeated START mid-byte, then a read.
    tx_push(8'h5A);
    do_start();
    send_byte(8'h74, ack);
    chk("t6_addr_ack", 32'(ack), 32'd1);
    base = int'(rx_cnt);
    for (int i = 0; i < 4; i++) bit_xfer(i[0], s);
    do_start();
    send_byte(8'h75, ack);
    chk("t6_raddr_ack", 32'(ack), 32'd1);
    chk("t6_srw", 32'(srw), 32'd1);
    recv_byte(d, 1'b0);
    chk("t6_byte", 32'(d), 32'h5A);
    do_stop();
    chk("t6_no_partial_wr", 32'(int'(rx_cnt) - base), 32'd0);

    // General-call address.
    base = int'(rx_cnt);
    do_start();
    send_byte(8'h00, ack);
`ifdef I2C_SLV_GC_EN
    chk("gc_ack", 32'(ack), 32'd1);
    chk("gc_hit", 32'({gc_hit, aas}), 32'd3);
    send_byte(8'h99, ack);
    chk("gc_data_ack", 32'(ack), 32'd1);
    do_stop();
    tick(4);
    chk("gc_byte", 32'(rx_mem[7'(base)]), 32'h99);
    chk("gc_clear", 32'(gc_hit), 32'd0);
`else
    chk("gc_nak", 32'(ack), 32'd0);
    chk("gc_hit_zero", 32'({gc_hit, aas}), 32'd0);
    do_stop();
`endif

    // Core disabled: no response, bus-busy still tracks.
    cr_en = 1'b0;
    do_start();
    send_byte(8'h74, ack);
    chk("dis_nak", 32'(ack), 32'd0);
    chk("dis_bb", 32'(bb), 32'd1);
    do_stop();
    tick(4);
    chk("dis_bb_clr", 32'(bb), 32'd0);
    cr_en = 1'b1;

    // Randomized transactions against the byte-level model.
    for (int it = 0; it < 8; it++) begin
      rw  = 1'($urandom_range(0, 1));
      hit = ($urandom_range(0, 2) != 0);
      addr = OWN;
      if (!hit) begin
        while (addr == OWN || addr == 7'h00) addr = 7'($urandom);
      end
      abyte   = {addr, rw};
      exp_ack = (abyte[7:1] == OWN);
      n       = $urandom_range(1, 3);
      base = int'(rx_cnt); rd0 = tx_rd_cnt; nak0 = nak_cnt; oe0 = sda_oe_cyc;
      exp_q.delete();
      if (rw && exp_ack) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          tx_push(d);
        end
      end
      do_start();
      send_byte(abyte, ack);
      chk("rnd_addr_ack", 32'(ack), 32'(exp_ack));
      if (!exp_ack) begin
        do_stop();
        chk("rnd_miss_quiet", 32'(sda_oe_cyc - oe0), 32'd0);
      end else if (!rw) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          send_byte(d, ack);
          chk("rnd_wr_ack", 32'(ack), 32'd1);
        end
        do_stop();
        tick(2);
        chk("rnd_wr_count", 32'(int'(rx_cnt) - base), 32'(n));
        for (int k = 0; k < n; k++)
          chk("rnd_wr_data", 32'(rx_mem[7'(base + k)]), 32'(exp_q[k]));
      end else begin
        for (int k = 0; k < n; k++) begin
          recv_byte(d, k != n - 1);
          chk("rnd_rd_data", 32'(d), 32'(exp_q[k]));
        end
        do_stop();
        chk("rnd_rd_count", 32'(tx_rd_cnt - rd0), 32'(n));
        chk("rnd_rd_nak", 32'(nak_cnt - nak0), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
